vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 132 +++++++++++++
 tb/tb_vram_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one single-port text RAM between three masters:
//   - video character fetch (highest priority, always granted)
//   - screen-clear sequencer (writes FILL to cells 0..CELLS-1)
//   - CPU read/write port (lowest priority, only served while idle)
//
// Ports:
//   CLK_25MHZ  : clock, all state updates on the rising edge
//   RESET      : synchronous active-high reset
//   VID_REQ/VID_ADDR                 : video fetch request and address
//   VID_VALID/VID_DATA               : video read data, one cycle after grant
//   CPU_REQ/CPU_WE/CPU_ADDR/CPU_WDATA: CPU request, held until CPU_READY
//   CPU_READY                        : CPU access performed this cycle
//   CPU_RVALID/CPU_RDATA             : CPU read data, one cycle after grant
//   CLR_START                        : one-cycle pulse that starts a clear
//   CLR_BUSY                         : high while the clear is running
//   RAM_ADDR/RAM_WE/RAM_WDATA        : RAM port, driven by the current owner
//   RAM_RDATA                        : RAM read data, one cycle latency
module vram_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CELLS  = 2400,
  parameter logic [7:0]  FILL   = 8'h20
) (
  input  logic              CLK_25MHZ,
  input  logic              RESET,
  input  logic              VID_REQ,
  input  logic [ADDR_W-1:0] VID_ADDR,
  output logic              VID_VALID,
  output logic [7:0]        VID_DATA,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [7:0]        CPU_WDATA,
  output logic              CPU_READY,
  output logic              CPU_RVALID,
  output logic [7:0]        CPU_RDATA,
  input  logic              CLR_START,
  output logic              CLR_BUSY,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [7:0]        RAM_WDATA,
  input  logic [7:0]        RAM_RDATA
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  // rd_pend: a read was issued last cycle; rd_owner: 1 = video, 0 = CPU
  logic              rd_pend;
  logic              rd_owner;

  logic vid_grant;
  logic clr_write;
  logic cpu_grant;

  // Grants are qualified with RESET so nothing touches the RAM on the reset
  // cycle itself, which also aborts an in-flight clear without a final write.
  always_comb begin
    vid_grant = VID_REQ & ~RESET;
    clr_write = (state == ST_CLEAR) & ~VID_REQ & ~RESET;
    cpu_grant = CPU_REQ & ~VID_REQ & (state == ST_IDLE) & ~RESET;
  end

  // RAM port mux: video > clear > CPU
  always_comb begin
    RAM_ADDR  = '0;
    RAM_WE    = 1'b0;
    RAM_WDATA = '0;
    if (vid_grant) begin
      RAM_ADDR = VID_ADDR;
    end else if (clr_write) begin
      RAM_ADDR  = clr_cnt;
      RAM_WE    = 1'b1;
      RAM_WDATA = FILL;
    end else if (cpu_grant) begin
      RAM_ADDR  = CPU_ADDR;
      RAM_WE    = CPU_WE;
      RAM_WDATA = CPU_WDATA;
    end
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      state    <= ST_IDLE;
      clr_cnt  <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= vid_grant | (cpu_grant & ~CPU_WE);
      rd_owner <= vid_grant;
      case (state)
        ST_IDLE: begin
          if (CLR_START) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          // Video cycles stall the sequencer; CLR_START is ignored here.
          if (!VID_REQ) begin
            if (clr_cnt == LAST_CELL) begin
              state   <= ST_IDLE;
              clr_cnt <= '0;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    CPU_READY  = cpu_grant;
    CLR_BUSY   = (state == ST_CLEAR) & ~RESET;
    VID_VALID  = rd_pend & rd_owner & ~RESET;
    CPU_RVALID = rd_pend & ~rd_owner & ~RESET;
    VID_DATA   = VID_VALID  ? RAM_RDATA : '0;
    CPU_RDATA  = CPU_RVALID ? RAM_RDATA : '0;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_req;
  logic [11:0] vid_addr;
  logic        vid_valid;
  logic [7:0]  vid_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        clr_start;
  logic        clr_busy;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // RAM model with write bookkeeping
  logic [7:0]  mem [0:4095];
  int unsigned wr_cnt [0:4095];
  int unsigned total_wr = 0;
  logic        fill_req = 1'b0;
  logic [7:0]  fill_val = 8'h00;
  int unsigned base [0:4095];
  int unsigned base_total;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(12), .CELLS(2400), .FILL(8'h20)) dut (
    .CLK_25MHZ (clk),
    .RESET     (rst),
    .VID_REQ   (vid_req),
    .VID_ADDR  (vid_addr),
    .VID_VALID (vid_valid),
    .VID_DATA  (vid_data),
    .CPU_REQ   (cpu_req),
    .CPU_WE    (cpu_we),
    .CPU_ADDR  (cpu_addr),
    .CPU_WDATA (cpu_wdata),
    .CPU_READY (cpu_ready),
    .CPU_RVALID(cpu_rvalid),
    .CPU_RDATA (cpu_rdata),
    .CLR_START (clr_start),
    .CLR_BUSY  (clr_busy),
    .RAM_ADDR  (ram_addr),
    .RAM_WE    (ram_we),
    .RAM_WDATA (ram_wdata),
    .RAM_RDATA (ram_rdata)
  );

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 4096; i++) mem[i] <= fill_val;
    end else if (ram_we) begin
      mem[ram_addr]    <= ram_wdata;
      wr_cnt[ram_addr] <= wr_cnt[ram_addr] + 1;
      total_wr         <= total_wr + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic snapshot();
    for (int i = 0; i < 4096; i++) base[i] = wr_cnt[i];
    base_total = total_wr;
  endtask

  task automatic idle_inputs();
    vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    clr_start = 1'b0;
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  int unsigned k;
  int unsigned bad;
  int unsigned ready_bad;
  int unsigned lo_bad;
  int unsigned hi_bad;
  bit          pulsed;
  bit          timed_out;

  initial begin
    idle_inputs();
    rst = 1'b1;
    // CPU request and video address present during reset must not leak out
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'h5A;
    step();
    step();
    settle();
    check("rst_cpu_ready",  cpu_ready,  0);
    check("rst_ram_we",     ram_we,     0);
    check("rst_ram_addr",   ram_addr,   0);
    check("rst_ram_wdata",  ram_wdata,  0);
    check("rst_clr_busy",   clr_busy,   0);
    check("rst_vid_valid",  vid_valid,  0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_vid_data",   vid_data,   0);
    check("rst_cpu_rdata",  cpu_rdata,  0);
    step();
    rst = 1'b0;
    idle_inputs();
    step();

    // CPU write then read back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h005; cpu_wdata = 8'h41;
    settle();
    check("wr_ready", cpu_ready, 1);
    check("wr_we",    ram_we,    1);
    check("wr_addr",  ram_addr,  12'h005);
    check("wr_data",  ram_wdata, 8'h41);
    step();
    cpu_we = 1'b0;
    settle();
    check("rd_ready",        cpu_ready,  1);
    check("rd_we",           ram_we,     0);
    check("rd_addr",         ram_addr,   12'h005);
    check("no_rvalid_after_write", cpu_rvalid, 0);
    step();
    cpu_req = 1'b0;
    settle();
    check("rd_rvalid",  cpu_rvalid, 1);
    check("rd_rdata",   cpu_rdata,  8'h41);
    check("rd_vvalid",  vid_valid,  0);
    step();
    settle();
    check("rd_rvalid_1shot", cpu_rvalid, 0);

    // Out-of-range address passes straight through
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'hFFF; cpu_wdata = 8'hC3;
    settle();
    check("oor_addr", ram_addr, 12'hFFF);
    step();
    cpu_req = 1'b0;
    cpu_write(12'h010, 8'h77);
    cpu_write(12'h100, 8'h99);

    // Video and CPU collide: video wins, CPU follows
    vid_req = 1'b1; vid_addr = 12'h100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    settle();
    check("col_cpu_ready", cpu_ready, 0);
    check("col_ram_addr",  ram_addr,  12'h100);
    check("col_ram_we",    ram_we,    0);
    step();
    vid_req = 1'b0;
    settle();
    check("col_vvalid",    vid_valid,  1);
    check("col_vdata",     vid_data,   8'h99);
    check("col_rvalid0",   cpu_rvalid, 0);
    check("col_cpu_ready2", cpu_ready, 1);
    check("col_ram_addr2", ram_addr,   12'h010);
    step();
    cpu_req = 1'b0;
    settle();
    check("col_rvalid",  cpu_rvalid, 1);
    check("col_rdata",   cpu_rdata,  8'h77);
    check("col_vvalid0", vid_valid,  0);
    step();

    // Reads granted right before reset yield no VALID afterwards
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    step();
    cpu_req = 1'b0;
    rst = 1'b1;
    settle();
    check("prerst_rvalid_in_rst", cpu_rvalid, 0);
    step();
    rst = 1'b0;
    settle();
    check("prerst_rvalid_after", cpu_rvalid, 0);
    vid_req = 1'b1; vid_addr = 12'h100;
    step();
    vid_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("prerst_vvalid_after", vid_valid, 0);
    step();

    // Clear with CPU request in the start cycle and held throughout
    clr_start = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h005; cpu_wdata = 8'h55;
    settle();
    check("cs_cpu_ready", cpu_ready, 1);
    check("cs_busy",      clr_busy,  0);
    step();
    snapshot();
    clr_start = 1'b0;
    cpu_addr = 12'hA00; cpu_wdata = 8'hAB;
    k = 0; ready_bad = 0; timed_out = 1'b1;
    while (k < 3000) begin
      settle();
      if (!clr_busy) begin
        timed_out = 1'b0;
        break;
      end
      if (k == 0) begin
        check("clr_first_addr", ram_addr,  0);
        check("clr_first_we",   ram_we,    1);
        check("clr_first_data", ram_wdata, 8'h20);
      end
      if (cpu_ready) ready_bad++;
      step();
      k++;
    end
    check("clr_timeout",   timed_out, 0);
    check("clr_cycles",    k,         2400);
    check("clr_cpu_held",  ready_bad, 0);
    check("clr_cpu_after", cpu_ready, 1);
    check("clr_cpu_addr",  ram_addr,  12'hA00);
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    bad = 0;
    for (int i = 0; i < 2400; i++)
      if (wr_cnt[i] - base[i] != 1 || mem[i] != 8'h20) bad++;
    check("clr_cells_bad",  bad, 0);
    check("clr_total_wr",   total_wr - base_total, 2401);
    check("clr_cpu_mem",    mem[12'hA00], 8'hAB);
    check("clr_oor_kept",   mem[12'hFFF], 8'hC3);

    // Clear interleaved with video, plus a restart attempt at counter 500
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    snapshot();
    k = 0; bad = 0; pulsed = 1'b0; timed_out = 1'b1;
    while (k < 6000) begin
      vid_req = (k % 2 == 0);
      vid_addr = 12'h100;
      clr_start = 1'b0;
      if (!pulsed && total_wr - base_total == 500) begin
        clr_start = 1'b1;
        pulsed = 1'b1;
      end
      settle();
      if (!clr_busy) begin
        timed_out = 1'b0;
        break;
      end
      if (vid_req && (ram_we || ram_addr != 12'h100)) bad++;
      if (!vid_req && !ram_we) bad++;
      step();
      k++;
    end
    vid_req = 1'b0; clr_start = 1'b0;
    check("vclr_timeout", timed_out, 0);
    check("vclr_pulsed",  pulsed,    1);
    check("vclr_len_ok",  (k >= 4799 && k <= 4801), 1);
    check("vclr_owner",   bad,       0);
    step();
    bad = 0;
    for (int i = 0; i < 2400; i++)
      if (wr_cnt[i] - base[i] != 1) bad++;
    check("vclr_once",     bad, 0);
    check("vclr_total_wr", total_wr - base_total, 2400);

    // Reset aborts a clear at counter 1000
    fill_val = 8'hEE;
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    snapshot();
    k = 0; timed_out = 1'b1;
    while (k < 3000) begin
      if (total_wr - base_total == 1000) begin
        timed_out = 1'b0;
        rst = 1'b1;
        settle();
        check("abort_we_in_rst", ram_we, 0);
        step();
        rst = 1'b0;
        settle();
        check("abort_busy", clr_busy, 0);
        check("abort_we",   ram_we,   0);
        break;
      end
      step();
      k++;
    end
    check("abort_timeout", timed_out, 0);
    step();
    step();
    lo_bad = 0; hi_bad = 0;
    for (int i = 0; i < 1000; i++)    if (mem[i] != 8'h20) lo_bad++;
    for (int i = 1000; i < 4096; i++) if (mem[i] != 8'hEE) hi_bad++;
    check("abort_lo_cleared", lo_bad, 0);
    check("abort_hi_kept",    hi_bad, 0);
    check("abort_total_wr",   total_wr - base_total, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
